// File: rtl/bench_report_pkg.sv
// Shared constants, FSM state type and nibble-to-ASCII helper for the
// benchmark result UART reporter.
package bench_report_pkg;

  localparam logic [7:0] ASCII_C  = 8'h43;
  localparam logic [7:0] ASCII_EQ = 8'h3D;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;

  localparam int LINE_LEN = 13;
  localparam int NUM_COND = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_FIN
  } state_t;

  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit,
// each held BIT_DIV cycles; accepts a new byte in the last stop cycle.
module uart_tx_byte #(
  parameter int BIT_DIV = 16
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       txd,
  output logic       ready
);

  localparam int DIV_W = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 2;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(BIT_DIV - 2);
  localparam logic [3:0]       STOP_BIT = 4'd9;

  logic             r_txd;
  logic             r_active;
  logic [8:0]       r_shift;
  logic [3:0]       r_bit_cnt;
  logic [DIV_W-1:0] r_div_cnt;
  logic             w_last_cycle;
  logic             w_accept;

  assign w_last_cycle = r_active && (r_bit_cnt == STOP_BIT) && (r_div_cnt == DIV_LAST);
  assign w_accept     = valid && (!r_active || w_last_cycle);

  // ready fires one cycle before the stop bit ends, so the parent's one-cycle
  // LOAD lands on the final stop cycle and the next start bit follows with no gap.
  assign ready = r_active && (r_bit_cnt == STOP_BIT) && (r_div_cnt == DIV_PRE);
  assign txd   = r_txd;

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_txd     <= 1'b1;
      r_active  <= 1'b0;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
    end else if (w_accept) begin
      r_txd     <= 1'b0;
      r_active  <= 1'b1;
      r_shift   <= {1'b1, data};
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
    end else if (r_active) begin
      if (r_div_cnt == DIV_LAST) begin
        r_div_cnt <= '0;
        if (r_bit_cnt == STOP_BIT) begin
          r_active <= 1'b0;
        end else begin
          r_txd     <= r_shift[0];
          r_shift   <= {1'b0, r_shift[8:1]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/bench_result_uart_tx.sv
// Captures four benchmark cycle counts on start and prints them over UART
// as "Cn=XXXXXXXX\r\n" lines, then pulses done.
module bench_result_uart_tx
  import bench_report_pkg::*;
#(
  parameter int CLK_HZ = 125000000,
  parameter int BAUD   = 115200
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] t_cond0,
  input  logic [31:0] t_cond1,
  input  logic [31:0] t_cond2,
  input  logic [31:0] t_cond3,
  output logic        busy,
  output logic        done,
  output logic        uart_txd
);

  localparam int         BIT_DIV   = CLK_HZ / BAUD;
  localparam logic [3:0] CHAR_LAST = 4'(LINE_LEN - 1);
  localparam logic [1:0] LINE_LAST = 2'(NUM_COND - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_cond [NUM_COND];
  logic [3:0]  r_char_idx;
  logic [1:0]  r_line_idx;
  logic        r_done;

  logic        w_accept;
  logic        w_valid;
  logic        w_ready;
  logic        w_last_char;
  logic [31:0] w_cur_val;
  logic [2:0]  w_nib_sel;
  logic [3:0]  w_nib;
  logic [7:0]  w_char;

  // The done cycle still counts as busy, so a start there is dropped.
  assign busy     = (r_state != S_IDLE) || r_done;
  assign done     = r_done;
  assign w_accept = (r_state == S_IDLE) && !r_done && start;

  assign w_last_char = (r_char_idx == CHAR_LAST) && (r_line_idx == LINE_LAST);
  assign w_cur_val   = r_cond[r_line_idx];
  assign w_nib_sel   = 3'(4'd10 - r_char_idx);
  assign w_nib       = w_cur_val[{w_nib_sel, 2'b00} +: 4];

  always_comb begin
    w_char = nib2ascii(w_nib);
    case (r_char_idx)
      4'd0:    w_char = ASCII_C;
      4'd1:    w_char = ASCII_0 + {6'b0, r_line_idx};
      4'd2:    w_char = ASCII_EQ;
      4'd11:   w_char = ASCII_CR;
      4'd12:   w_char = ASCII_LF;
      default: w_char = nib2ascii(w_nib);
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (w_accept) begin
      r_cond[0] <= t_cond0;
      r_cond[1] <= t_cond1;
      r_cond[2] <= t_cond2;
      r_cond[3] <= t_cond3;
    end
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_char_idx <= '0;
      r_line_idx <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= (r_state == S_FIN);
      if (w_accept) begin
        r_char_idx <= '0;
        r_line_idx <= '0;
      end else if ((r_state == S_SEND) && w_ready && !w_last_char) begin
        if (r_char_idx == CHAR_LAST) begin
          r_char_idx <= '0;
          r_line_idx <= r_line_idx + 2'd1;
        end else begin
          r_char_idx <= r_char_idx + 4'd1;
        end
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_valid      = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_next_state = S_LOAD;
      S_LOAD: begin
        w_valid      = 1'b1;
        w_next_state = S_SEND;
      end
      S_SEND: if (w_ready) w_next_state = w_last_char ? S_FIN : S_LOAD;
      S_FIN:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  uart_tx_byte #(
    .BIT_DIV(BIT_DIV)
  ) u_tx (
    .sysclk(sysclk),
    .rst_n (rst_n),
    .valid (w_valid),
    .data  (w_char),
    .txd   (uart_txd),
    .ready (w_ready)
  );

endmodule

// File: tb/tb_bench_result_uart_tx.sv
// Directed bench for bench_result_uart_tx at BIT_DIV=16: decodes each report
// bit-by-bit against hand-written expected strings and checks handshake timing.
module tb_bench_result_uart_tx;

  logic        sysclk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] t_cond0, t_cond1, t_cond2, t_cond3;
  logic        busy, done, uart_txd;

  int n_cmp = 0;
  int n_err = 0;

  string exp_a = "C0=00000000\015\nC1=0000000A\015\nC2=12345678\015\nC3=FFFFFFFF\015\n";
  string exp_b = "C0=DEADBEEF\015\nC1=00C0FFEE\015\nC2=80000001\015\nC3=0F0F0F0F\015\n";
  string exp_c = "C0=9ABCDEF0\015\nC1=00000001\015\nC2=7FFFFFFF\015\nC3=10000000\015\n";
  string exp_d = "C0=CAFEF00D\015\nC1=01234567\015\nC2=89ABCDEF\015\nC3=A5A55A5A\015\n";
  string exp_e = "C0=00000000\015\nC1=FFFFFFFF\015\nC2=0000FFFF\015\nC3=FFFF0000\015\n";

  // clock / reset
  always #5 sysclk = ~sysclk;

  bench_result_uart_tx #(
    .CLK_HZ(16),
    .BAUD  (1)
  ) dut (
    .sysclk  (sysclk),
    .rst_n   (rst_n),
    .start   (start),
    .t_cond0 (t_cond0),
    .t_cond1 (t_cond1),
    .t_cond2 (t_cond2),
    .t_cond3 (t_cond3),
    .busy    (busy),
    .done    (done),
    .uart_txd(uart_txd)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_cmp++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp_v, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge sysclk);
    #1;
  endtask

  task automatic set_conds(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d);
    t_cond0 = a;
    t_cond1 = b;
    t_cond2 = c;
    t_cond3 = d;
  endtask

  // One-cycle start pulse; optionally scramble the inputs the following cycle.
  task automatic do_start(input bit scramble);
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    if (scramble) set_conds(~t_cond0, ~t_cond1, ~t_cond2, ~t_cond3);
    @(negedge sysclk);
    check_eq("pre_fall_txd", {31'b0, uart_txd}, 32'd1);
    check_eq("busy_rise", {31'b0, busy}, 32'd1);
    next_cycle();
  endtask

  // Samples every cycle of every bit; poke_cyc pulses start mid-report.
  task automatic rx_report(input string exp_s, input int nbytes, input int poke_cyc);
    int cyc = 0;
    int bad_bits = 0;
    int done_seen = 0;
    int busy_low = 0;
    for (int b = 0; b < nbytes; b++) begin
      logic [7:0] e;
      logic [7:0] got;
      logic [9:0] frame;
      e     = exp_s[b];
      frame = {1'b1, e, 1'b0};
      got   = '0;
      for (int bi = 0; bi < 10; bi++) begin
        for (int k = 0; k < 16; k++) begin
          if (cyc == poke_cyc) start = 1'b1;
          else if (cyc == poke_cyc + 1) start = 1'b0;
          @(negedge sysclk);
          if (uart_txd !== frame[bi]) bad_bits++;
          if (k == 8 && bi >= 1 && bi <= 8) got[bi-1] = uart_txd;
          if (done !== 1'b0) done_seen++;
          if (busy !== 1'b1) busy_low++;
          next_cycle();
          cyc++;
        end
      end
      check_eq($sformatf("byte%0d", b), {24'b0, got}, {24'b0, e});
    end
    check_eq("bit_samples", bad_bits, 0);
    check_eq("early_done", done_seen, 0);
    check_eq("busy_low", busy_low, 0);
  endtask

  task automatic check_done_cycle();
    @(negedge sysclk);
    check_eq("done_pulse", {31'b0, done}, 32'd1);
    check_eq("busy_in_done", {31'b0, busy}, 32'd1);
    next_cycle();
  endtask

  task automatic check_idle_cycle();
    @(negedge sysclk);
    check_eq("done_width", {31'b0, done}, 32'd0);
    check_eq("busy_after", {31'b0, busy}, 32'd0);
    check_eq("txd_idle", {31'b0, uart_txd}, 32'd1);
    next_cycle();
  endtask

  initial begin
    int bad;
    rst_n = 1'b0;
    start = 1'b0;
    set_conds(32'h0, 32'h0, 32'h0, 32'h0);
    repeat (4) next_cycle();
    @(negedge sysclk);
    check_eq("rst_txd", {31'b0, uart_txd}, 32'd1);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    repeat (2) next_cycle();

    // basic report, first-fall latency and done at exactly 8320 cycles
    set_conds(32'h00000000, 32'h0000000A, 32'h12345678, 32'hFFFFFFFF);
    do_start(1'b0);
    rx_report(exp_a, 52, -1);
    check_done_cycle();
    check_idle_cycle();

    // inputs scrambled after capture, extra start mid-report, start on done
    set_conds(32'hDEADBEEF, 32'h00C0FFEE, 32'h80000001, 32'h0F0F0F0F);
    do_start(1'b1);
    rx_report(exp_b, 52, 3000);
    set_conds(32'h9ABCDEF0, 32'h00000001, 32'h7FFFFFFF, 32'h10000000);
    start = 1'b1;
    check_done_cycle();
    @(negedge sysclk);
    check_eq("busy_post_done", {31'b0, busy}, 32'd0);
    next_cycle();
    start = 1'b0;
    @(negedge sysclk);
    check_eq("no_done_cycle_accept", {31'b0, uart_txd}, 32'd1);
    check_eq("accept_after_done", {31'b0, busy}, 32'd1);
    next_cycle();
    rx_report(exp_c, 52, -1);
    check_done_cycle();
    check_idle_cycle();

    // reset during byte 20 aborts without done
    set_conds(32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF, 32'hA5A55A5A);
    do_start(1'b0);
    rx_report(exp_d, 20, -1);
    repeat (40) next_cycle();
    rst_n = 1'b0;
    next_cycle();
    @(negedge sysclk);
    check_eq("abort_txd", {31'b0, uart_txd}, 32'd1);
    check_eq("abort_busy", {31'b0, busy}, 32'd0);
    check_eq("abort_done", {31'b0, done}, 32'd0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sysclk);
      if (done !== 1'b0 || uart_txd !== 1'b1 || busy !== 1'b0) bad++;
      next_cycle();
    end
    check_eq("abort_quiet", bad, 0);

    set_conds(32'h00000000, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000);
    do_start(1'b0);
    rx_report(exp_e, 52, -1);
    check_done_cycle();
    check_idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
